// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, debug halt, branch redirects
// and MEM-stage traps into the hold vector, flush/redirect PC and stall watchdog.
module pipe_ctrl #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        halt_req,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_addr_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_vec_i,
  output logic [4:0]  stalled_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        trap_ack_o,
  output logic        timeout_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_TIMEOUT);
  localparam logic             WD_EN = (STALL_TIMEOUT != 0);

  logic [1:0]       state_q, state_d;
  logic [31:0]      vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [4:0]  idle_stall;
  logic        req_stall;
  logic [4:0]  stalled;
  logic        flush;
  logic        ack;
  logic [31:0] new_pc;

  // Priority merge of stall sources while IDLE; halt outranks every request.
  always_comb begin
    // NOTE: every signal gets a default before the if/case so no latch is inferred.
    idle_stall = 5'b00000;
    req_stall  = 1'b0;
    if (halt_req) begin
      idle_stall = 5'b11111;
    end else if (stallreq_mem) begin
      idle_stall = 5'b01111;
      req_stall  = 1'b1;
    end else if (stallreq_ex) begin
      idle_stall = 5'b00111;
      req_stall  = 1'b1;
    end else if (stallreq_id) begin
      idle_stall = 5'b00011;
      req_stall  = 1'b1;
    end else if (stallreq_if) begin
      idle_stall = 5'b00001;
      req_stall  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    stalled = 5'b00000;
    flush   = 1'b0;
    ack     = 1'b0;
    new_pc  = 32'h0;
    case (state_q)
      S_IDLE: begin
        stalled = idle_stall;
        if (trap_req_i) begin
          // Trap wins over a same-cycle branch; the branch is simply dropped.
          state_d = S_DRAIN;
          vec_d   = trap_vec_i;
        end else if (halt_req) begin
          state_d = S_HALT;
        end else if (branch_flag_i && !idle_stall[3]) begin
          flush  = 1'b1;
          new_pc = branch_addr_i;
        end
      end
      S_DRAIN: begin
        stalled = 5'b01111;
        if (!stallreq_mem) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        flush   = 1'b1;
        new_pc  = vec_q;
        ack     = 1'b1;
        state_d = S_IDLE;
      end
      S_HALT: begin
        stalled = 5'b11111;
        if (!halt_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Watchdog counts consecutive request stalls in IDLE and saturates at the limit.
  always_comb begin
    cnt_d     = '0;
    timeout_d = 1'b0;
    if (state_q == S_IDLE && req_stall) begin
      cnt_d     = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
      timeout_d = WD_EN && (cnt_q != LIMIT) && (cnt_d == LIMIT);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      vec_q     <= 32'h0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held, independent of inputs.
  assign stalled_o  = rst ? stalled : 5'b00000;
  assign flush_o    = rst & flush;
  assign new_pc_o   = rst ? new_pc : 32'h0;
  assign trap_ack_o = rst & ack;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, branch, trap drain, watchdog, async reset.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        halt_req;
  logic        branch_flag_i;
  logic [31:0] branch_addr_i;
  logic        trap_req_i;
  logic [31:0] trap_vec_i;
  logic [4:0]  stalled_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        trap_ack_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.STALL_TIMEOUT(4), .CNT_W(11)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .halt_req      (halt_req),
    .branch_flag_i (branch_flag_i),
    .branch_addr_i (branch_addr_i),
    .trap_req_i    (trap_req_i),
    .trap_vec_i    (trap_vec_i),
    .stalled_o     (stalled_o),
    .flush_o       (flush_o),
    .new_pc_o      (new_pc_o),
    .trap_ack_o    (trap_ack_o),
    .timeout_o     (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; combinational checks follow 1 unit later.
  task automatic edge_then;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic check_comb(input string tag, input logic [4:0] st, input logic fl,
                            input logic [31:0] pc, input logic ak);
    check({tag, ".stalled"}, 32'(stalled_o), 32'(st));
    check({tag, ".flush"},   32'(flush_o),   32'(fl));
    check({tag, ".new_pc"},  new_pc_o,       pc);
    check({tag, ".ack"},     32'(trap_ack_o), 32'(ak));
  endtask

  initial begin
    rst = 1'b0;
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    halt_req = 0; branch_flag_i = 0; branch_addr_i = 32'h0;
    trap_req_i = 0; trap_vec_i = 32'h0;

    // Reset state, with a stall request present to prove outputs are forced to 0
    stallreq_mem = 1'b1;
    #3;
    check_comb("reset", 5'b00000, 1'b0, 32'h0, 1'b0);
    check("reset.timeout", 32'(timeout_o), 32'h0);
    stallreq_mem = 1'b0;
    edge_then();
    edge_then();
    rst = 1'b1;

    // Stall priority
    edge_then(); stallreq_id = 1'b1; settle();
    check_comb("prio_id", 5'b00011, 1'b0, 32'h0, 1'b0);
    edge_then(); stallreq_mem = 1'b1; settle();
    check_comb("prio_mem", 5'b01111, 1'b0, 32'h0, 1'b0);
    edge_then(); halt_req = 1'b1; settle();
    check_comb("prio_halt", 5'b11111, 1'b0, 32'h0, 1'b0);
    edge_then(); halt_req = 0; stallreq_mem = 0; stallreq_id = 0; settle();
    check_comb("halt_exit", 5'b11111, 1'b0, 32'h0, 1'b0);
    edge_then(); settle();
    check_comb("released", 5'b00000, 1'b0, 32'h0, 1'b0);
    stallreq_if = 1'b1; settle();
    check_comb("prio_if", 5'b00001, 1'b0, 32'h0, 1'b0);
    stallreq_if = 1'b0;

    // Branch: immediate, deferred under MEM stall, allowed under EX stall
    edge_then(); branch_flag_i = 1'b1; branch_addr_i = 32'h0000_0100; settle();
    check_comb("br_now", 5'b00000, 1'b1, 32'h100, 1'b0);
    edge_then(); stallreq_mem = 1'b1; settle();
    check_comb("br_wait1", 5'b01111, 1'b0, 32'h0, 1'b0);
    edge_then(); settle();
    check_comb("br_wait2", 5'b01111, 1'b0, 32'h0, 1'b0);
    edge_then(); stallreq_mem = 1'b0; settle();
    check_comb("br_go", 5'b00000, 1'b1, 32'h100, 1'b0);
    edge_then(); stallreq_ex = 1'b1; settle();
    check_comb("br_ex", 5'b00111, 1'b1, 32'h100, 1'b0);
    edge_then(); stallreq_ex = 1'b0; branch_flag_i = 1'b0; settle();
    check_comb("br_off", 5'b00000, 1'b0, 32'h0, 1'b0);

    // Trap with 3-cycle drain
    edge_then(); trap_req_i = 1'b1; trap_vec_i = 32'h0000_0004; stallreq_mem = 1'b1; settle();
    check_comb("trap_idle", 5'b01111, 1'b0, 32'h0, 1'b0);
    edge_then(); settle();
    check_comb("drain1", 5'b01111, 1'b0, 32'h0, 1'b0);
    edge_then(); settle();
    check_comb("drain2", 5'b01111, 1'b0, 32'h0, 1'b0);
    edge_then(); stallreq_mem = 1'b0; settle();
    check_comb("drain3", 5'b01111, 1'b0, 32'h0, 1'b0);
    edge_then(); settle();
    check_comb("trap_flush", 5'b00000, 1'b1, 32'h4, 1'b1);
    edge_then(); trap_req_i = 1'b0; settle();
    check_comb("trap_done", 5'b00000, 1'b0, 32'h0, 1'b0);

    // Trap and branch in the same IDLE cycle: trap wins
    edge_then(); trap_req_i = 1'b1; trap_vec_i = 32'h0000_0040;
    branch_flag_i = 1'b1; branch_addr_i = 32'h0000_0200; settle();
    check_comb("tvb_idle", 5'b00000, 1'b0, 32'h0, 1'b0);
    edge_then(); settle();
    check_comb("tvb_drain", 5'b01111, 1'b0, 32'h0, 1'b0);
    edge_then(); settle();
    check_comb("tvb_flush", 5'b00000, 1'b1, 32'h40, 1'b1);
    edge_then(); trap_req_i = 1'b0; branch_flag_i = 1'b0; settle();
    check_comb("tvb_done", 5'b00000, 1'b0, 32'h0, 1'b0);

    // Watchdog: pulse after the 4th stalled edge only, then again after re-raise
    stallreq_ex = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      edge_then();
      check($sformatf("wd_a%0d", i), 32'(timeout_o), 32'(i == 4));
    end
    stallreq_ex = 1'b0;
    edge_then();
    check("wd_drop", 32'(timeout_o), 32'h0);
    stallreq_ex = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      edge_then();
      check($sformatf("wd_b%0d", i), 32'(timeout_o), 32'(i == 4));
    end
    stallreq_ex = 1'b0;
    halt_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      edge_then();
      check($sformatf("wd_halt%0d", i), 32'(timeout_o), 32'h0);
    end
    halt_req = 1'b0;
    edge_then();
    edge_then(); settle();
    check_comb("halt_idle", 5'b00000, 1'b0, 32'h0, 1'b0);

    // Async reset during DRAIN
    trap_req_i = 1'b1; trap_vec_i = 32'h0000_0008; stallreq_mem = 1'b1;
    edge_then(); settle();
    check_comb("rst_drain", 5'b01111, 1'b0, 32'h0, 1'b0);
    rst = 1'b0; settle();
    check_comb("rst_async", 5'b00000, 1'b0, 32'h0, 1'b0);
    trap_req_i = 1'b0; stallreq_mem = 1'b0;
    edge_then();
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      edge_then(); settle();
      check_comb($sformatf("post_rst%0d", i), 5'b00000, 1'b0, 32'h0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time in case the stimulus sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage yadan core.
- Merges stall requests from IF/ID/EX/MEM, debug halt, EX branch redirects and MEM-stage traps.
- Produces the stalled[4:0] hold vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb; the flush and redirect PC; and a stall-watchdog timeout pulse.
- Bit mapping of stalled: 0 = pc/if, 1 = if_id, 2 = id_ex, 3 = ex_mem, 4 = mem_wb. 1 = hold, 0 = NoStop.

Parameters:
STALL_TIMEOUT, 1024, consecutive request-stall cycles before timeout_o pulses; 0 disables the watchdog.
CNT_W, 11, watchdog counter width; must hold STALL_TIMEOUT.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-low reset
stallreq_if  input  1  fetch bus wait
stallreq_id  input  1  load-use hazard
stallreq_ex  input  1  multi-cycle ALU busy
stallreq_mem  input  1  data bus wait
halt_req  input  1  debug halt, level
branch_flag_i  input  1  EX taken branch/jump
branch_addr_i  input  32  branch target
trap_req_i  input  1  MEM-stage exception/interrupt, level, held until trap_ack_o
trap_vec_i  input  32  trap target
stalled_o  output  5  stage hold vector
flush_o  output  1  clear if_id and id_ex to NOP
new_pc_o  output  32  redirect address, valid when flush_o=1
trap_ack_o  output  1  one-cycle trap-taken pulse
timeout_o  output  1  one-cycle watchdog pulse

Behaviour:
- Reset (rst=0, async): state=IDLE, latched vector=0, counter=0, all outputs 0 (stalled_o=5'b00000). Reset mid-trap or mid-halt returns to IDLE with no flush.
- stalled_o, flush_o, new_pc_o and trap_ack_o are combinational from state and inputs. State, latched vector, counter and timeout_o are registered.
- IDLE stall priority (first match wins):
  - halt_req: 5'b11111
  - stallreq_mem: 5'b01111
  - stallreq_ex: 5'b00111
  - stallreq_id: 5'b00011
  - stallreq_if: 5'b00001
  - none: 5'b00000
- Branch, IDLE only:
  - Condition: branch_flag_i=1, stalled_o[3]=0, trap_req_i=0, halt_req=0.
  - Then flush_o=1 and new_pc_o=branch_addr_i in the same cycle.
  - Otherwise the branch is deferred; EX holds it while stalled.
- FSM states: IDLE, DRAIN, FLUSH, HALT.
  - IDLE -> HALT: halt_req=1 and trap_req_i=0.
  - IDLE -> DRAIN: trap_req_i=1. trap_vec_i is latched; a same-cycle branch is dropped (trap wins).
  - DRAIN: stalled_o=5'b01111; flush_o=0. Go to FLUSH when stallreq_mem=0, otherwise stay. Minimum 1 cycle.
  - FLUSH, exactly 1 cycle: stalled_o=5'b00000, flush_o=1, new_pc_o=latched vector, trap_ack_o=1. Then go to IDLE.
  - HALT: stalled_o=5'b11111; trap and branch are ignored (sources hold them). Go to IDLE when halt_req=0.
- Trap latency: trap_req_i rise to trap_ack_o is at least 2 cycles, i.e. 1 + stallreq_mem cycles seen in DRAIN.
- Watchdog:
  - Counter increments each cycle the state is IDLE and stalled_o != 0 due to a stall request (not halt). Otherwise it clears to 0.
  - When the counter reaches STALL_TIMEOUT, timeout_o=1 for exactly one cycle, then the counter saturates with no further pulse until it clears.
  - STALL_TIMEOUT=0: timeout_o stays 0.
- new_pc_o=0 whenever flush_o=0.

Test Plan:
- Stall priority: stallreq_id=1 -> stalled_o=5'b00011. Add stallreq_mem=1 -> 5'b01111. Add halt_req=1 -> 5'b11111. Release all -> 5'b00000.
- Branch: IDLE, branch_flag_i=1, branch_addr_i=32'h0000_0100 -> same-cycle flush_o=1, new_pc_o=32'h100. Repeat with stallreq_mem=1 -> flush_o=0 until the MEM stall drops, then flush with 32'h100.
- Trap with drain: trap_req_i=1, trap_vec_i=32'h0000_0004, stallreq_mem=1 for 3 cycles -> DRAIN with stalled_o=5'b01111 for 3 cycles. Next cycle: flush_o=1, new_pc_o=32'h4, trap_ack_o=1 for one cycle. Then IDLE.
- Trap vs branch: trap_req_i and branch_flag_i (addr 32'h200) in the same IDLE cycle -> no flush to 32'h200. After 2 cycles, flush to the trap vector.
- Watchdog (STALL_TIMEOUT=4): stallreq_ex held 10 cycles -> timeout_o high on exactly the 4th stalled cycle, once. Drop and re-raise -> pulses again after 4 cycles. halt_req held 10 cycles -> no pulse.
- Async reset: assert rst=0 during DRAIN -> stalled_o=0, flush_o=0 immediately. After release, state is IDLE and no trap_ack_o occurs unless trap_req_i is re-asserted.
